// File: rtl/sys_bus_rr.sv
// N-master / M-slave shared bus with round-robin arbitration and a req/ack handshake.
// Optional BUSY watchdog enabled by defining SYS_BUS_TIMEOUT_EN.
module sys_bus_rr #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned NUM_SLAVES     = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        mst_req_i,
  input  logic [NUM_MASTERS-1:0]        mst_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] mst_adr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] mst_wdata_i,
  output logic [NUM_MASTERS*DATA_W-1:0] mst_rdata_o,
  output logic [NUM_MASTERS-1:0]        mst_ack_o,
  output logic [NUM_MASTERS-1:0]        mst_err_o,
  output logic [NUM_MASTERS-1:0]        mst_stall_o,
  output logic [NUM_SLAVES-1:0]         slv_req_o,
  output logic                          slv_we_o,
  output logic [ADDR_W-1:0]             slv_adr_o,
  output logic [DATA_W-1:0]             slv_wdata_o,
  input  logic [NUM_SLAVES*DATA_W-1:0]  slv_rdata_i,
  input  logic [NUM_SLAVES-1:0]         slv_ack_i
);

  localparam int unsigned MIDX_W = $clog2(NUM_MASTERS);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [MIDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [MIDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [MIDX_W-1:0] win_idx;
  logic              win_found;

  logic              busy, gnt_req, active, mapped;
  logic              done_ok, done_err, done, tmo_hit;
  logic [ADDR_W-1:0] gnt_adr;
  logic [DATA_W-1:0] gnt_wdata;
  logic [3:0]        sel;
  logic [NUM_SLAVES-1:0] sel_onehot;
  logic              sel_ack;
  logic [DATA_W-1:0] sel_rdata;

  assign busy      = (state_q == BUSY);
  assign gnt_req   = mst_req_i[grant_idx_q];
  assign gnt_adr   = mst_adr_i[32'(grant_idx_q)*ADDR_W +: ADDR_W];
  assign gnt_wdata = mst_wdata_i[32'(grant_idx_q)*DATA_W +: DATA_W];
  assign sel       = gnt_adr[ADDR_W-1 -: 4];
  assign active    = busy & gnt_req;

  // Slave k answers to sel == k+1; everything else stays all-zero (unmapped).
  always_comb begin
    sel_onehot = '0;
    sel_ack    = 1'b0;
    sel_rdata  = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (32'(sel) == k + 1) begin
        sel_onehot[k] = 1'b1;
        sel_ack       = slv_ack_i[k];
        sel_rdata     = slv_rdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign mapped   = |sel_onehot;
  assign done_ok  = active & mapped & sel_ack;
  assign done_err = active & (~mapped | (tmo_hit & ~sel_ack));
  assign done     = done_ok | done_err;

`ifdef SYS_BUS_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Held at zero in IDLE so every BUSY phase starts counting from 0.
  always_comb begin
    tmo_cnt_d = '0;
    if (busy && !sel_ack) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end

  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  // Arbitration scans upward from rr_ptr with wrap; an abort leaves rr_ptr untouched.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    win_found   = 1'b0;
    win_idx     = rr_ptr_q;
    for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
      if (!win_found && mst_req_i[MIDX_W'((32'(rr_ptr_q) + off) % NUM_MASTERS)]) begin
        win_found = 1'b1;
        win_idx   = MIDX_W'((32'(rr_ptr_q) + off) % NUM_MASTERS);
      end
    end
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_idx_d = win_idx;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (!gnt_req) begin
          state_d = IDLE;
        end else if (done) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_idx_q == MIDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx_q + MIDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slave side is live only while a mapped, still-requested transfer is pending.
  always_comb begin
    mst_rdata_o = '0;
    mst_ack_o   = '0;
    mst_err_o   = '0;
    slv_req_o   = '0;
    slv_we_o    = 1'b0;
    slv_adr_o   = '0;
    slv_wdata_o = '0;
    if (active && mapped && !tmo_hit) begin
      slv_req_o   = sel_onehot;
      slv_we_o    = mst_we_i[grant_idx_q];
      slv_adr_o   = gnt_adr;
      slv_wdata_o = gnt_wdata;
    end
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (MIDX_W'(i) == grant_idx_q) begin
        mst_ack_o[i]                    = done;
        mst_err_o[i]                    = done_err;
        mst_rdata_o[i*DATA_W +: DATA_W] = done_ok ? sel_rdata : '0;
      end
    end
    mst_stall_o = rst ? '0 : (mst_req_i & ~mst_ack_o);
  end

endmodule

// File: tb/tb_sys_bus_rr.sv
// Self-checking bench for sys_bus_rr: behavioural slaves plus an ack scoreboard.
module tb_sys_bus_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mst_req, mst_we, mst_ack, mst_err, mst_stall, slv_req, slv_ack;
  logic [63:0] mst_adr, mst_wdata, mst_rdata, slv_rdata;
  logic        slv_we;
  logic [31:0] slv_adr, slv_wdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          lat [2];
  logic [31:0] srd [2];
  int          scnt [2];

  typedef struct {int m; logic [31:0] rdata; logic err; logic [1:0] sreq; logic [1:0] stall; int cyc;} obs_t;
  typedef struct {int m; logic [31:0] rdata; logic err; logic [1:0] sreq;} exp_t;
  obs_t obs_q[$];
  exp_t exp_q[$];

  sys_bus_rr dut (
    .clk(clk), .rst(rst),
    .mst_req_i(mst_req), .mst_we_i(mst_we), .mst_adr_i(mst_adr), .mst_wdata_i(mst_wdata),
    .mst_rdata_o(mst_rdata), .mst_ack_o(mst_ack), .mst_err_o(mst_err), .mst_stall_o(mst_stall),
    .slv_req_o(slv_req), .slv_we_o(slv_we), .slv_adr_o(slv_adr), .slv_wdata_o(slv_wdata),
    .slv_rdata_i(slv_rdata), .slv_ack_i(slv_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave k acks on its lat[k]-th selected cycle (lat 1 = combinational ack, 0 = never).
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      scnt[k] <= (slv_req[k] && !slv_ack[k]) ? scnt[k] + 1 : 0;
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      slv_ack[k]           = slv_req[k] && (lat[k] != 0) && (scnt[k] + 1 >= lat[k]);
      slv_rdata[k*32 +: 32] = srd[k];
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++)
      if (mst_ack[m] === 1'b1)
        obs_q.push_back('{m, mst_rdata[m*32 +: 32], mst_err[m], slv_req, mst_stall, cyc});
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_m(input int m, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    mst_req[m]           = r;
    mst_we[m]            = w;
    mst_adr[m*32 +: 32]  = a;
    mst_wdata[m*32 +: 32] = d;
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mst_req = '0;
    tick(); tick();
    rst = 1'b0;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_read();
    tick();
    lat[0] = 1; srd[0] = 32'h1234_5678;
    set_m(0, 1'b1, 1'b0, 32'h1000_0010, 32'h0);
    exp_q.push_back('{0, 32'h1234_5678, 1'b0, 2'b01});
    @(negedge clk); #1;
    total++;
    if ({slv_req, mst_ack} !== 4'b0) begin bad++; $display("FAIL read_idle_quiet got=%b exp=0000", {slv_req, mst_ack}); end
    @(negedge clk); #1;
    total++;
    if (slv_req !== 2'b01 || mst_ack !== 2'b01 || mst_err !== 2'b00 || slv_adr !== 32'h1000_0010) begin
      bad++; $display("FAIL read_busy got sreq=%b ack=%b err=%b adr=%h exp sreq=01 ack=01 err=00 adr=10000010", slv_req, mst_ack, mst_err, slv_adr);
    end
    total++;
    if (mst_rdata[31:0] !== 32'h1234_5678) begin bad++; $display("FAIL read_rdata got=%h exp=12345678", mst_rdata[31:0]); end
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    while (exp_q.size() != 0) begin
      exp_t e; obs_t o;
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL read_sb got=none exp=m%0d", e.m); end
      else begin
        o = obs_q.pop_front();
        if (o.m !== e.m || o.rdata !== e.rdata || o.err !== e.err || o.sreq !== e.sreq) begin
          bad++; $display("FAIL read_sb got m%0d %h err=%b sreq=%b exp m%0d %h err=%b sreq=%b", o.m, o.rdata, o.err, o.sreq, e.m, e.rdata, e.err, e.sreq);
        end
      end
    end
  endtask

  task automatic test_reset();
    tick();
    lat[0] = 0; lat[1] = 1; srd[1] = 32'hB1B1_0001;
    set_m(0, 1'b1, 1'b1, 32'h1000_0000, 32'hDEAD_BEEF);
    @(negedge clk); #1;
    @(negedge clk); #1;
    total++;
    if (slv_req !== 2'b01) begin bad++; $display("FAIL rst_pre_busy got=%b exp=01", slv_req); end
    rst = 1'b1;
    set_m(1, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
    #1;
    total++;
    if (slv_req !== 2'b00) begin bad++; $display("FAIL rst_slv_req_drop got=%b exp=00", slv_req); end
    total++;
    if ({mst_ack, mst_err, mst_stall, slv_we} !== 7'b0 || mst_rdata !== 64'b0 || slv_adr !== 32'b0 || slv_wdata !== 32'b0) begin
      bad++; $display("FAIL rst_outputs got ack=%b err=%b stall=%b we=%b rdata=%h adr=%h wd=%h exp all zero", mst_ack, mst_err, mst_stall, slv_we, mst_rdata, slv_adr, slv_wdata);
    end
    lat[0] = 1; srd[0] = 32'h0000_A000;
    tick(); tick();
    rst = 1'b0;
    exp_q.push_back('{0, 32'h0000_A000, 1'b0, 2'b01});
    exp_q.push_back('{1, 32'hB1B1_0001, 1'b0, 2'b10});
    wait_obs(2, 20);
    mst_req = '0;
    while (exp_q.size() != 0) begin
      exp_t e; obs_t o;
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL rst_sb got=none exp=m%0d", e.m); end
      else begin
        o = obs_q.pop_front();
        if (o.m !== e.m || o.rdata !== e.rdata || o.err !== e.err || o.sreq !== e.sreq) begin
          bad++; $display("FAIL rst_sb got m%0d %h err=%b sreq=%b exp m%0d %h err=%b sreq=%b", o.m, o.rdata, o.err, o.sreq, e.m, e.rdata, e.err, e.sreq);
        end
      end
    end
  endtask

  task automatic test_rr();
    int c0;
    do_reset();
    lat[0] = 1; lat[1] = 1; srd[0] = 32'h1111_0000; srd[1] = 32'h2222_0000;
    c0 = cyc;
    set_m(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h2000_0008, 32'h0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{0, 32'h1111_0000, 1'b0, 2'b01});
      exp_q.push_back('{1, 32'h2222_0000, 1'b0, 2'b10});
    end
    wait_obs(4, 30);
    mst_req = '0;
    total++;
    if (obs_q.size() != 4) begin bad++; $display("FAIL rr_count got=%0d exp=4", obs_q.size()); end
    else begin
      total++;
      if (obs_q[0].cyc - c0 != 1) begin bad++; $display("FAIL rr_latency got=%0d exp=1", obs_q[0].cyc - c0); end
      total++;
      if (obs_q[2].cyc - obs_q[0].cyc != 4 || obs_q[3].cyc - obs_q[1].cyc != 4) begin
        bad++; $display("FAIL rr_spacing got=%0d,%0d exp=4,4", obs_q[2].cyc - obs_q[0].cyc, obs_q[3].cyc - obs_q[1].cyc);
      end
      total++;
      if (obs_q[0].stall !== 2'b10 || obs_q[1].stall !== 2'b01) begin
        bad++; $display("FAIL rr_stall got=%b,%b exp=10,01", obs_q[0].stall, obs_q[1].stall);
      end
    end
    while (exp_q.size() != 0) begin
      exp_t e; obs_t o;
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL rr_sb got=none exp=m%0d", e.m); end
      else begin
        o = obs_q.pop_front();
        if (o.m !== e.m || o.rdata !== e.rdata || o.err !== e.err || o.sreq !== e.sreq) begin
          bad++; $display("FAIL rr_sb got m%0d %h err=%b sreq=%b exp m%0d %h err=%b sreq=%b", o.m, o.rdata, o.err, o.sreq, e.m, e.rdata, e.err, e.sreq);
        end
      end
    end
  endtask

  task automatic test_write();
    tick();
    lat[1] = 3; srd[1] = 32'h5555_AAAA;
    set_m(1, 1'b1, 1'b1, 32'h2000_0004, 32'hCAFE_F00D);
    exp_q.push_back('{1, 32'h5555_AAAA, 1'b0, 2'b10});
    @(negedge clk); #1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      total++;
      if (slv_req !== 2'b10 || slv_we !== 1'b1 || slv_wdata !== 32'hCAFE_F00D || slv_adr !== 32'h2000_0004 ||
          mst_ack !== ((c == 3) ? 2'b10 : 2'b00)) begin
        bad++; $display("FAIL write_c%0d got sreq=%b we=%b wd=%h adr=%h ack=%b exp sreq=10 we=1 wd=cafef00d adr=20000004 ack=%b",
                        c, slv_req, slv_we, slv_wdata, slv_adr, mst_ack, (c == 3) ? 2'b10 : 2'b00);
      end
    end
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    while (exp_q.size() != 0) begin
      exp_t e; obs_t o;
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL write_sb got=none exp=m%0d", e.m); end
      else begin
        o = obs_q.pop_front();
        if (o.m !== e.m || o.rdata !== e.rdata || o.err !== e.err || o.sreq !== e.sreq) begin
          bad++; $display("FAIL write_sb got m%0d %h err=%b sreq=%b exp m%0d %h err=%b sreq=%b", o.m, o.rdata, o.err, o.sreq, e.m, e.rdata, e.err, e.sreq);
        end
      end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [4];
    int c0;
    addrs[0] = 32'h5000_0000; addrs[1] = 32'h0000_0000; addrs[2] = 32'h3000_0000; addrs[3] = 32'hF000_0010;
    lat[0] = 1; lat[1] = 1; srd[0] = 32'hEEEE_0000; srd[1] = 32'hEEEE_0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      c0 = cyc;
      set_m(0, 1'b1, 1'b0, addrs[i], 32'h0);
      exp_q.push_back('{0, 32'h0, 1'b1, 2'b00});
      wait_obs(obs_q.size() + 1, 10);
      set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
      total++;
      if (obs_q.size() == 0 || obs_q[obs_q.size()-1].cyc - c0 != 1) begin
        bad++; $display("FAIL unmapped_latency addr=%h got=%0d exp=1", addrs[i], (obs_q.size() == 0) ? -1 : obs_q[obs_q.size()-1].cyc - c0);
      end
    end
    while (exp_q.size() != 0) begin
      exp_t e; obs_t o;
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL unmapped_sb got=none exp=m%0d", e.m); end
      else begin
        o = obs_q.pop_front();
        if (o.m !== e.m || o.rdata !== e.rdata || o.err !== e.err || o.sreq !== e.sreq) begin
          bad++; $display("FAIL unmapped_sb got m%0d %h err=%b sreq=%b exp m%0d %h err=%b sreq=%b", o.m, o.rdata, o.err, o.sreq, e.m, e.rdata, e.err, e.sreq);
        end
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    lat[0] = 0;
    set_m(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    repeat (6) begin @(negedge clk); #1; end
    total++;
    if (slv_req !== 2'b01) begin bad++; $display("FAIL abort_pre got=%b exp=01", slv_req); end
    set_m(0, 1'b0, 1'b0, 32'h1000_0000, 32'h0);
    #1;
    total++;
    if (slv_req !== 2'b00 || mst_ack !== 2'b00) begin bad++; $display("FAIL abort_drop got sreq=%b ack=%b exp sreq=00 ack=00", slv_req, mst_ack); end
    tick(); tick();
    lat[0] = 1; lat[1] = 1; srd[0] = 32'hA0A0_0000; srd[1] = 32'hA1A1_0000;
    set_m(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
    exp_q.push_back('{0, 32'hA0A0_0000, 1'b0, 2'b01});
    exp_q.push_back('{1, 32'hA1A1_0000, 1'b0, 2'b10});
    wait_obs(2, 20);
    mst_req = '0;
    while (exp_q.size() != 0) begin
      exp_t e; obs_t o;
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL abort_sb got=none exp=m%0d", e.m); end
      else begin
        o = obs_q.pop_front();
        if (o.m !== e.m || o.rdata !== e.rdata || o.err !== e.err || o.sreq !== e.sreq) begin
          bad++; $display("FAIL abort_sb got m%0d %h err=%b sreq=%b exp m%0d %h err=%b sreq=%b", o.m, o.rdata, o.err, o.sreq, e.m, e.rdata, e.err, e.sreq);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int c0;
    do_reset();
    lat[0] = 0;
    c0 = cyc;
    set_m(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
`ifdef SYS_BUS_TIMEOUT_EN
    wait_obs(1, 40);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++;
    if (obs_q.size() != 1) begin bad++; $display("FAIL tmo_count got=%0d exp=1", obs_q.size()); end
    else if (obs_q[0].cyc - c0 != 17 || obs_q[0].err !== 1'b1 || obs_q[0].rdata !== 32'h0 || obs_q[0].sreq !== 2'b00) begin
      bad++; $display("FAIL tmo_pulse got dly=%0d err=%b rdata=%h sreq=%b exp dly=17 err=1 rdata=0 sreq=00",
                      obs_q[0].cyc - c0, obs_q[0].err, obs_q[0].rdata, obs_q[0].sreq);
    end
`else
    repeat (100) begin @(negedge clk); #1; end
    total++;
    if (obs_q.size() != 0 || mst_stall[0] !== 1'b1 || slv_req !== 2'b01) begin
      bad++; $display("FAIL hang got acks=%0d stall0=%b sreq=%b exp acks=0 stall0=1 sreq=01", obs_q.size(), mst_stall[0], slv_req);
    end
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
`endif
    tick(); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mst_req = '0; mst_we = '0; mst_adr = '0; mst_wdata = '0;
    lat[0] = 1; lat[1] = 1; srd[0] = '0; srd[1] = '0;
    do_reset();
    test_read();
    test_reset();
    test_rr();
    test_write();
    test_unmapped();
    test_abort();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
